pps_timestamp_capture: RTL

//  Downstream consumer of the free-running clock-edge counter. Synchronises an external
//  PPS/trigger input, latches edge_count on each PPS rising edge, computes the cycle delta

---
 rtl/pps_timestamp_capture_pkg.sv | 19 +
 rtl/pps_timestamp_capture_if.sv | 25 ++
 rtl/pps_timestamp_capture_fifo.sv | 55 +++++
 rtl/pps_timestamp_capture.sv | 130 +++++++++++++
 4 files changed

// File: rtl/pps_timestamp_capture_pkg.sv
// Shared definitions for the PPS timestamp capture block: tuser bit positions,
// capture FSM states and the saturating drop-counter helper.
package pps_timestamp_capture_pkg;

  localparam int TS_TUSER_FIRST = 0;
  localparam int TS_TUSER_GAP   = 1;
  localparam int OVF_CNT_W      = 16;

  typedef enum logic [1:0] {
    DISARMED,
    ARMED,
    RUNNING
  } cap_state_t;

  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/pps_timestamp_capture_if.sv
// Timestamp record stream: {delta, count} data plus first/gap flags on valid/ready.
interface pps_timestamp_capture_if #(
  parameter int COUNTER_WIDTH = 64
) ();

  logic [2*COUNTER_WIDTH-1:0] ts_tdata;
  logic [1:0]                 ts_tuser;
  logic                       ts_tvalid;
  logic                       ts_tready;

  modport master (
    output ts_tdata,
    output ts_tuser,
    output ts_tvalid,
    input  ts_tready
  );

  modport slave (
    input  ts_tdata,
    input  ts_tuser,
    input  ts_tvalid,
    output ts_tready
  );

endinterface

// File: rtl/pps_timestamp_capture_fifo.sv
// Small synchronous first-word-fall-through FIFO holding timestamp records.
// The head word is presented combinationally and reads as zero while empty.
module ts_capture_fifo #(
  parameter int WIDTH = 130,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign pop_ok   = pop & ~empty;
  // A full queue still takes a word when the head leaves in the same cycle.
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pps_timestamp_capture.sv
// Synchronises PPS, latches edge_count on each rising edge, computes the cycle delta
// to the previous edge and queues {delta, count} records on a valid/ready stream.
module pps_timestamp_capture
  import pps_timestamp_capture_pkg::*;
#(
  parameter int COUNTER_WIDTH = 64,
  parameter int SYNC_STAGES   = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic [COUNTER_WIDTH-1:0] edge_count,
  input  logic                     pps_in,
  input  logic                     capture_enable,
  pps_timestamp_capture_if.master  ts,
  output logic [OVF_CNT_W-1:0]     overflow_count,
  output logic                     pps_seen
);

  localparam int REC_W = 2*COUNTER_WIDTH + 2;

  logic [SYNC_STAGES-1:0]   sync_reg;
  logic [SYNC_STAGES-1:0]   primed_reg;
  logic                     hist_reg;
  logic                     edge_pulse_reg;
  cap_state_t               state_reg;
  logic [COUNTER_WIDTH-1:0] prev_reg;
  logic                     gap_pending_reg;
  logic [OVF_CNT_W-1:0]     overflow_count_reg;
  logic                     pps_seen_reg;

  logic                     sync_out;
  logic                     primed;
  logic                     capture;
  logic                     room;
  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [COUNTER_WIDTH-1:0] delta;
  logic [1:0]               push_user;
  logic [REC_W-1:0]         push_data;
  logic [REC_W-1:0]         head_data;

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign primed   = primed_reg[SYNC_STAGES-1];

  // History is held at 1 until the chain has flushed its reset zeros, so a PPS that
  // was already high when reset released never looks like a fresh rising edge.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_reg       <= '0;
      primed_reg     <= '0;
      hist_reg       <= 1'b1;
      edge_pulse_reg <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[SYNC_STAGES-2:0], pps_in};
      primed_reg     <= {primed_reg[SYNC_STAGES-2:0], 1'b1};
      hist_reg       <= primed ? sync_out : 1'b1;
      edge_pulse_reg <= sync_out & ~hist_reg;
    end
  end

  assign pop     = ts.ts_tvalid & ts.ts_tready;
  assign capture = edge_pulse_reg & capture_enable & (state_reg != DISARMED);
  assign room    = ~fifo_full | pop;
  assign push    = capture & room;
  assign delta   = (state_reg == ARMED) ? '0 : edge_count - prev_reg;

  always_comb begin
    push_user                 = '0;
    push_user[TS_TUSER_FIRST] = (state_reg == ARMED);
    push_user[TS_TUSER_GAP]   = gap_pending_reg;
  end

  assign push_data = {push_user, delta, edge_count};

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_reg          <= DISARMED;
      prev_reg           <= '0;
      gap_pending_reg    <= 1'b0;
      overflow_count_reg <= '0;
      pps_seen_reg       <= 1'b0;
    end else if (!capture_enable) begin
      state_reg       <= DISARMED;
      gap_pending_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        DISARMED: state_reg <= ARMED;
        ARMED, RUNNING: begin
          if (edge_pulse_reg) begin
            // A dropped edge still becomes the delta reference for the next record.
            prev_reg     <= edge_count;
            state_reg    <= RUNNING;
            pps_seen_reg <= 1'b1;
            if (room) begin
              gap_pending_reg <= 1'b0;
            end else begin
              gap_pending_reg    <= 1'b1;
              overflow_count_reg <= sat_inc(overflow_count_reg);
            end
          end
        end
        default: state_reg <= DISARMED;
      endcase
    end
  end

  ts_capture_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ts.ts_tvalid   = ~fifo_empty;
  assign ts.ts_tdata    = head_data[2*COUNTER_WIDTH-1:0];
  assign ts.ts_tuser    = head_data[REC_W-1:2*COUNTER_WIDTH];
  assign overflow_count = overflow_count_reg;
  assign pps_seen       = pps_seen_reg;

endmodule
